// File: rtl/midi_msg_parser_if.sv
// FIFO-side and message-side signals of the MIDI parser.
// The parser uses the master modport; the FIFO/consumer side uses slave.
interface midi_msg_parser_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       err_pulse;
  logic [7:0] err_count;

  modport master (
    input  fifo_empty, fifo_data, msg_ready,
    output fifo_rd, msg_valid, msg_status, msg_data1, msg_data2,
           rt_valid, rt_byte, err_pulse, err_count
  );
  modport slave (
    output fifo_empty, fifo_data, msg_ready,
    input  fifo_rd, msg_valid, msg_status, msg_data1, msg_data2,
           rt_valid, rt_byte, err_pulse, err_count
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, SysEx discard, channel filter, timeout.
// Define MIDI_RT_PASS_EN to forward real-time bytes on rt_valid/rt_byte.
module midi_msg_parser #(
  parameter logic [15:0] CHAN_MASK = 16'hFFFF,
  parameter int          TIMEOUT   = 0,
  parameter int          TIMEOUT_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  midi_msg_parser_if.master bus
);
  typedef enum logic [2:0] {IDLE, DATA1, DATA2, SYSEX, HOLD} state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state, state_n;
  logic                 rd_pend;
  logic [7:0]           rs, rs_n;
  logic                 rs_vld, rs_vld_n;
  logic [6:0]           d1, d1_n;
  logic                 cmp, err;
  logic [6:0]           cmp_d1, cmp_d2;
  logic                 in_data, tmo_hit, vel0;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [7:0]           b;

  assign b       = bus.fifo_data;
  assign in_data = (state == DATA1) || (state == DATA2);
  assign tmo_hit = (TIMEOUT > 0) && in_data && !rd_pend && (tmo_cnt == TMO_LAST);
  assign vel0    = (rs[7:4] == 4'h9) && (cmp_d2 == 7'h00);
  assign bus.fifo_rd = !Reset && !bus.fifo_empty && !rd_pend && (state != HOLD);

`ifdef MIDI_RT_PASS_EN
  logic rt_hit;
`endif

  always_comb begin
    state_n  = state;
    rs_n     = rs;
    rs_vld_n = rs_vld;
    d1_n     = d1;
    err      = 1'b0;
    cmp      = 1'b0;
    cmp_d1   = d1;
    cmp_d2   = 7'h00;
`ifdef MIDI_RT_PASS_EN
    rt_hit   = 1'b0;
`endif
    if (state == HOLD && bus.msg_valid && bus.msg_ready) state_n = IDLE;
    if (rd_pend) begin
      if (b >= 8'hF8) begin
`ifdef MIDI_RT_PASS_EN
        rt_hit = 1'b1;
`endif
      end else if (state != HOLD) begin
        if (state == SYSEX && b == 8'hF7) state_n = IDLE;
        else if (!(state == SYSEX && !b[7])) begin
          if (b == 8'hF0) begin
            rs_vld_n = 1'b0;
            state_n  = SYSEX;
          end else if (b[7:4] == 4'hF) begin
            rs_vld_n = 1'b0;
            state_n  = IDLE;
          end else if (b[7]) begin
            err      = in_data;
            rs_n     = b;
            rs_vld_n = 1'b1;
            state_n  = DATA1;
          end else if (state == DATA2) begin
            cmp    = 1'b1;
            cmp_d2 = b[6:0];
          end else if (rs_vld) begin
            d1_n   = b[6:0];
            cmp_d1 = b[6:0];
            if (rs[7:5] == 3'b110) cmp = 1'b1;
            else                   state_n = DATA2;
          end else err = 1'b1;
        end
      end
    end else if (tmo_hit) begin
      err      = 1'b1;
      rs_vld_n = 1'b0;
      state_n  = IDLE;
    end
    // completed messages on filtered channels vanish silently
    if (cmp) state_n = CHAN_MASK[rs[3:0]] ? HOLD : IDLE;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= IDLE;
      rd_pend        <= 1'b0;
      rs             <= 8'h00;
      rs_vld         <= 1'b0;
      d1             <= 7'h00;
      tmo_cnt        <= '0;
      bus.msg_valid  <= 1'b0;
      bus.msg_status <= 8'h00;
      bus.msg_data1  <= 7'h00;
      bus.msg_data2  <= 7'h00;
      bus.err_pulse  <= 1'b0;
      bus.err_count  <= 8'h00;
    end else begin
      state     <= state_n;
      rd_pend   <= bus.fifo_rd;
      rs        <= rs_n;
      rs_vld    <= rs_vld_n;
      d1        <= d1_n;
      tmo_cnt   <= (rd_pend || !in_data) ? '0 : tmo_cnt + 1'b1;
      if (cmp && CHAN_MASK[rs[3:0]]) begin
        bus.msg_valid  <= 1'b1;
        bus.msg_status <= vel0 ? {4'h8, rs[3:0]} : rs;
        bus.msg_data1  <= cmp_d1;
        bus.msg_data2  <= vel0 ? 7'h40 : cmp_d2;
      end else if (bus.msg_valid && bus.msg_ready) begin
        bus.msg_valid <= 1'b0;
      end
      bus.err_pulse <= err;
      if (err && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
    end
  end

`ifdef MIDI_RT_PASS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.rt_valid <= 1'b0;
      bus.rt_byte  <= 8'h00;
    end else begin
      bus.rt_valid <= rt_hit;
      if (rt_hit) bus.rt_byte <= b;
    end
  end
`else
  assign bus.rt_valid = 1'b0;
  assign bus.rt_byte  = 8'h00;
`endif
endmodule
